// File: rtl/systolic_feeder4x4_if.sv
// Host write port, run handshake and array control bundle
// for the 4x4 systolic feeder.
//   master: host side (drives writes/start, sees status + array drive)
//   slave : feeder side (owns busy/done and every array control/data)
interface systolic_feeder4x4_if #(
    parameter int DATA_W = 16
);
    logic                   wr_en;
    logic                   wr_sel;
    logic [1:0]             wr_row;
    logic [0:3][DATA_W-1:0] wr_data;
    logic                   start;

    logic                   busy;
    logic                   done;
    logic                   data_clear;
    logic                   en_b_shift_bottom;
    logic                   en_shift_right;
    logic                   en_shift_bottom;
    logic [0:3][DATA_W-1:0] a_left_in_flat;
    logic [0:3][DATA_W-1:0] b_top_in_flat;
    logic [0:3][DATA_W-1:0] ps_top_in_flat;

    modport master (
        output wr_en, wr_sel, wr_row, wr_data, start,
        input  busy, done, data_clear,
        input  en_b_shift_bottom, en_shift_right, en_shift_bottom,
        input  a_left_in_flat, b_top_in_flat, ps_top_in_flat
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_data, start,
        output busy, done, data_clear,
        output en_b_shift_bottom, en_shift_right, en_shift_bottom,
        output a_left_in_flat, b_top_in_flat, ps_top_in_flat
    );
endinterface

// File: rtl/systolic_feeder4x4.sv
// Sequencer for the 4x4 weight-stationary array: buffers A and B,
// then runs CLEAR -> LOAD_B (4) -> STREAM (skewed A) -> DONE.
//   Clock, rst_n : clock and async active-low reset
//   bus (slave)  : host writes/start in, status and array drive out
module systolic_feeder4x4 #(
    parameter int DATA_W        = 16,
    parameter int STREAM_CYCLES = 14
) (
    input  logic             Clock,
    input  logic             rst_n,
    systolic_feeder4x4_if.slave bus
);
    localparam int CNT_W = $clog2(STREAM_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STREAM_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, LOAD_B, STREAM, DONE
    } state_t;

    state_t                 state;
    logic [1:0]             load_cnt;
    logic [CNT_W-1:0]       stream_cnt;
    logic [DATA_W-1:0]      a_buf [4][4];
    logic [DATA_W-1:0]      b_buf [4][4];

    logic [1:0]             load_nxt;
    logic [1:0]             b_src;
    logic [CNT_W:0]         feed_t;
    logic [0:3][DATA_W-1:0] b_row_nxt;
    logic [0:3][DATA_W-1:0] a_skew_nxt;

    assign bus.ps_top_in_flat = '0;

    // Outputs are registered, so the data for the coming cycle is
    // formed from the counter value that cycle will hold.
    always_comb begin
        load_nxt = (state == CLEAR) ? 2'd0 : load_cnt + 2'd1;
        // B enters bottom row first: step k feeds row 3-k.
        b_src = ~load_nxt;
        feed_t = (state == LOAD_B) ? '0
               : {1'b0, stream_cnt} + (CNT_W+1)'(1);
        for (int j = 0; j < 4; j++)
            b_row_nxt[j] = b_buf[b_src][j];
        for (int i = 0; i < 4; i++) begin
            a_skew_nxt[i] = '0;
            if (int'(feed_t) >= i && int'(feed_t) <= i + 3)
                a_skew_nxt[i] = a_buf[2'(int'(feed_t) - i)][i];
        end
    end

    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= IDLE;
            load_cnt              <= '0;
            stream_cnt            <= '0;
            bus.busy              <= 1'b0;
            bus.done              <= 1'b0;
            bus.data_clear        <= 1'b0;
            bus.en_b_shift_bottom <= 1'b0;
            bus.en_shift_right    <= 1'b0;
            bus.en_shift_bottom   <= 1'b0;
            bus.a_left_in_flat    <= '0;
            bus.b_top_in_flat     <= '0;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    a_buf[r][c] <= '0;
                    b_buf[r][c] <= '0;
                end
        end else begin
            bus.done              <= 1'b0;
            bus.data_clear        <= 1'b0;
            bus.en_b_shift_bottom <= 1'b0;
            bus.en_shift_right    <= 1'b0;
            bus.en_shift_bottom   <= 1'b0;
            bus.a_left_in_flat    <= '0;
            bus.b_top_in_flat     <= '0;
            unique case (state)
                IDLE: begin
                    if (bus.wr_en) begin
                        for (int c = 0; c < 4; c++) begin
                            if (bus.wr_sel)
                                b_buf[bus.wr_row][c] <= bus.wr_data[c];
                            else
                                a_buf[bus.wr_row][c] <= bus.wr_data[c];
                        end
                    end
                    if (bus.start) begin
                        state          <= CLEAR;
                        bus.busy       <= 1'b1;
                        bus.data_clear <= 1'b1;
                    end
                end
                CLEAR: begin
                    state                 <= LOAD_B;
                    load_cnt              <= load_nxt;
                    bus.en_b_shift_bottom <= 1'b1;
                    bus.b_top_in_flat     <= b_row_nxt;
                end
                LOAD_B: begin
                    if (load_cnt == 2'd3) begin
                        state               <= STREAM;
                        stream_cnt          <= '0;
                        bus.en_shift_right  <= 1'b1;
                        bus.en_shift_bottom <= 1'b1;
                        bus.a_left_in_flat  <= a_skew_nxt;
                    end else begin
                        load_cnt              <= load_nxt;
                        bus.en_b_shift_bottom <= 1'b1;
                        bus.b_top_in_flat     <= b_row_nxt;
                    end
                end
                STREAM: begin
                    if (stream_cnt == LAST) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        stream_cnt          <= stream_cnt + CNT_W'(1);
                        bus.en_shift_right  <= 1'b1;
                        bus.en_shift_bottom <= 1'b1;
                        bus.a_left_in_flat  <= a_skew_nxt;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_feeder4x4.sv
// Bench for systolic_feeder4x4: schedule model checked every cycle
// plus directed literal expectations.
module tb_systolic_feeder4x4;
    localparam int DW     = 16;
    localparam int SC     = 14;
    localparam int DONE_N = SC + 6;

    typedef logic [0:3][DW-1:0] row_t;

    logic Clock = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    bit   cmp_en = 1'b0;
    time  last_edge = 0;
    time  e0 = 0;

    systolic_feeder4x4_if #(.DATA_W(DW)) bus ();

    systolic_feeder4x4 #(
        .DATA_W(DW),
        .STREAM_CYCLES(SC)
    ) dut (
        .Clock(Clock),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name,
                         input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Model: mn = cycles since the start edge (0 = idle).
    // 1 clear, 2..5 load B rows 3..0, 6.. stream t=mn-6, DONE_N done.
    logic [DW-1:0] ma [4][4];
    logic [DW-1:0] mb [4][4];
    int mn = 0;

    always @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            mn <= 0;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    ma[r][c] <= '0;
                    mb[r][c] <= '0;
                end
        end else if (mn == 0) begin
            if (bus.wr_en)
                for (int c = 0; c < 4; c++) begin
                    if (bus.wr_sel) mb[bus.wr_row][c] <= bus.wr_data[c];
                    else            ma[bus.wr_row][c] <= bus.wr_data[c];
                end
            if (bus.start) mn <= 1;
        end else begin
            mn <= (mn == DONE_N) ? 0 : mn + 1;
        end
    end

    always @(negedge Clock) begin
        row_t ea;
        row_t eb;
        int   t;
        if (cmp_en) begin
            ea = '0;
            eb = '0;
            t  = mn - 6;
            if (mn >= 2 && mn <= 5)
                for (int j = 0; j < 4; j++) eb[j] = mb[5 - mn][j];
            if (mn >= 6 && mn < DONE_N)
                for (int i = 0; i < 4; i++)
                    if (t - i >= 0 && t - i <= 3) ea[i] = ma[t - i][i];
            check("busy", bus.busy, mn >= 1 && mn < DONE_N);
            check("done", bus.done, mn == DONE_N);
            check("data_clear", bus.data_clear, mn == 1);
            check("en_b", bus.en_b_shift_bottom, mn >= 2 && mn <= 5);
            check("en_right", bus.en_shift_right,
                  mn >= 6 && mn < DONE_N);
            check("en_bottom", bus.en_shift_bottom,
                  mn >= 6 && mn < DONE_N);
            check("a_left", bus.a_left_in_flat, ea);
            check("b_top", bus.b_top_in_flat, eb);
            check("ps_top", bus.ps_top_in_flat, '0);
        end
    end

    task automatic tick();
        @(posedge Clock);
        last_edge = $time;
        #1;
    endtask

    task automatic wr(input bit sel, input int row, input row_t d);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_row  = 2'(row);
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic go();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        e0 = last_edge;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (bus.done !== 1'b1) check({name, "_timeout"}, 0, 1);
        else check({name, "_edge"}, (last_edge - e0) / 10, 19);
    endtask

    task automatic check_idle_zero(input string name);
        check({name, "_busy"}, bus.busy, 0);
        check({name, "_done"}, bus.done, 0);
        check({name, "_ctl"}, {bus.data_clear, bus.en_b_shift_bottom,
              bus.en_shift_right, bus.en_shift_bottom}, 0);
        check({name, "_a"}, bus.a_left_in_flat, '0);
        check({name, "_b"}, bus.b_top_in_flat, '0);
    endtask

    initial begin
        row_t d;
        row_t exp;
        bus.wr_en   = 1'b0;
        bus.wr_sel  = 1'b0;
        bus.wr_row  = 2'd0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        tick();
        cmp_en = 1'b1;
        tick();
        rst_n = 1'b1;
        check_idle_zero("reset");

        // Load sequence and skew
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) d[c] = DW'(16 * r + c);
            wr(1'b1, r, d);
        end
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 4; i++) d[i] = DW'(256 * m + i);
            wr(1'b0, m, d);
        end
        go();
        check("clear_lit", bus.data_clear, 1);
        tick();
        exp = {16'd48, 16'd49, 16'd50, 16'd51};
        check("load0_lit", bus.b_top_in_flat, exp);
        check("load0_en", bus.en_b_shift_bottom, 1);
        tick();
        exp = {16'd32, 16'd33, 16'd34, 16'd35};
        check("load1_lit", bus.b_top_in_flat, exp);
        tick();
        exp = {16'd16, 16'd17, 16'd18, 16'd19};
        check("load2_lit", bus.b_top_in_flat, exp);
        tick();
        exp = {16'd0, 16'd1, 16'd2, 16'd3};
        check("load3_lit", bus.b_top_in_flat, exp);
        tick();
        check("t0_a_lit", bus.a_left_in_flat, '0);
        check("t0_en_lit", bus.en_shift_right, 1);
        repeat (3) tick();
        exp = {16'h300, 16'h201, 16'h102, 16'h003};
        check("t3_a_lit", bus.a_left_in_flat, exp);
        repeat (4) tick();
        check("t7_a_lit", bus.a_left_in_flat, '0);
        check("t7_en_lit", bus.en_shift_bottom, 1);
        wait_done("run1");
        tick();
        check("after_done", {bus.done, bus.busy}, 0);

        // Second start mid-run ignored; write during run dropped
        go();
        repeat (4) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        d = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        wr(1'b0, 0, d);
        wait_done("run2");
        repeat (3) tick();
        check("single_run", bus.busy, 0);
        go();
        repeat (8) tick();
        exp = {16'h300, 16'h201, 16'h102, 16'h003};
        check("replay_t3_lit", bus.a_left_in_flat, exp);
        wait_done("run3");
        tick();

        // Write and start in the same idle cycle
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b1;
        bus.wr_row  = 2'd3;
        bus.wr_data = {16'd7, 16'd7, 16'd7, 16'd7};
        go();
        bus.wr_en = 1'b0;
        tick();
        exp = {16'd7, 16'd7, 16'd7, 16'd7};
        check("same_cyc_lit", bus.b_top_in_flat, exp);
        wait_done("run4");

        // start on the done cycle ignored, next cycle accepted
        bus.start = 1'b1;
        tick();
        check("b2b_ignored", {bus.busy, bus.data_clear}, 0);
        tick();
        bus.start = 1'b0;
        e0 = last_edge;
        check("b2b_start", bus.data_clear, 1);
        wait_done("run5");
        tick();

        // Async reset mid-stream clears everything
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 4; i++)
                d[i] = DW'($urandom_range(1, 65535));
            wr(1'b0, m, d);
        end
        go();
        repeat (9) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_zero("mid_reset");
        tick();
        tick();
        rst_n = 1'b1;
        go();
        tick();
        check("rst_buf_b_en", bus.en_b_shift_bottom, 1);
        check("rst_buf_b", bus.b_top_in_flat, '0);
        repeat (7) tick();
        check("rst_buf_a", bus.a_left_in_flat, '0);
        wait_done("run6");
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
